// File: rtl/mac_pkg.sv
// Shared definitions for the serial shift-add MAC sequencer: default widths and FSM states.
package mac_pkg;

    localparam int OP_W_DEF  = 5;
    localparam int ACC_W_DEF = 16;
    localparam int CNT_W     = $clog2(OP_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } mac_state_e;

endpackage

// File: rtl/mac_serial_sequencer_if.sv
// Operand/result bus of the MAC sequencer. Both sides use valid/ready: a transfer happens on
// the rising edge where valid and ready are both high; valid never depends on ready.
interface mac_serial_sequencer_if
    import mac_pkg::*;
#(
    parameter int OP_W  = OP_W_DEF,
    parameter int ACC_W = ACC_W_DEF
);

    logic [OP_W-1:0]  a_i;
    logic [OP_W-1:0]  b_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             acc_clear_i;
    logic [ACC_W-1:0] acc_o;
    logic             ovf_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [1:0]       dbg_state_o;

    modport master (
        output a_i, b_i, in_valid_i, acc_clear_i, out_ready_i,
        input  in_ready_o, acc_o, ovf_o, out_valid_o, dbg_state_o
    );

    modport slave (
        input  a_i, b_i, in_valid_i, acc_clear_i, out_ready_i,
        output in_ready_o, acc_o, ovf_o, out_valid_o, dbg_state_o
    );

endinterface

// File: rtl/mac_shift_add_unit.sv
// Bit-serial multiplier datapath: multiplier rotates out LSB first, one shifted partial
// product of the multiplicand is added per step.
module mac_shift_add_unit #(
    parameter int OP_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [2*OP_W-1:0] prod_o,
    output logic              last_o
);

    localparam int CW = (OP_W > 1) ? $clog2(OP_W) : 1;

    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_sh_q, b_sh_d;
    logic [2*OP_W-1:0] prod_q, prod_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*OP_W-1:0] addend;

    assign addend = b_sh_q[0] ? ({{OP_W{1'b0}}, a_q} << cnt_q) : '0;

    always_comb begin
        a_d    = a_q;
        b_sh_d = b_sh_q;
        prod_d = prod_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            a_d    = a_i;
            b_sh_d = b_i;
            prod_d = '0;
            cnt_d  = '0;
        end else if (step_i) begin
            prod_d = prod_q + addend;
            b_sh_d = {b_sh_q[0], b_sh_q[OP_W-1:1]};
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_sh_q <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_sh_q <= b_sh_d;
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
        end
    end

    assign prod_o = prod_q;
    assign last_o = (cnt_q == CW'(OP_W - 1));

endmodule

// File: rtl/mac_serial_sequencer.sv
// Sequencer for the serial MAC: accepts an operand pair, runs OP_W shift-add steps, folds the
// product into a wrapping accumulator with sticky overflow and offers the result downstream.
module mac_serial_sequencer
    import mac_pkg::*;
#(
    parameter int OP_W  = OP_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                   reg_clk_i,
    input  logic                   reg_reset_i,
    mac_serial_sequencer_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_MUL  = 2'(MUL);
    localparam logic [1:0] S_ACC  = 2'(ACC);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic              accept;
    logic              step;
    logic              last;
    logic [2*OP_W-1:0] prod;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W:0]    sum;

    assign accept = (state_q == S_IDLE) && bus.in_valid_i;
    assign step   = (state_q == S_MUL);

    mac_shift_add_unit #(.OP_W(OP_W)) u_shift_add (
        .clk_i  (reg_clk_i),
        .rst_i  (reg_reset_i),
        .load_i (accept),
        .step_i (step),
        .a_i    (bus.a_i),
        .b_i    (bus.b_i),
        .prod_o (prod),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid_i) state_d = S_MUL;
            S_MUL:   if (last) state_d = S_ACC;
            S_ACC:   state_d = S_DONE;
            S_DONE:  if (bus.out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A clear arriving in ACC drops the old value but still takes this product.
    assign acc_base = bus.acc_clear_i ? '0 : acc_q;
    assign sum      = {1'b0, acc_base} + {{(ACC_W + 1 - 2*OP_W){1'b0}}, prod};

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (state_q == S_ACC) begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = (bus.acc_clear_i ? 1'b0 : ovf_q) | sum[ACC_W];
        end else if (bus.acc_clear_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge reg_clk_i) begin
        if (reg_reset_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.out_valid_o = (state_q == S_DONE);
    assign bus.acc_o       = acc_q;
    assign bus.ovf_o       = ovf_q;
    assign bus.dbg_state_o = state_q;

endmodule
